keygen_sched: RTL and testbench

//  Parametrised Kyber key-generation front end. Holds seeds rho/sigma loaded by register writes.
//  On START, streams a descriptor sequence with valid/ready: rho words, k*k A-matrix XOF jobs,

---
 rtl/kyber_pkg.sv | 30 +++
 rtl/keygen_seed_rf.sv | 28 ++
 rtl/keygen_sched.sv | 181 ++++++++++++++++++
 tb/tb_keygen_sched.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// Shared encodings for the Kyber key-generation front end: host commands,
// output beat tags, scheduler states and the rank bound of the 3-bit counters.
package kyber_pkg;

  localparam int CMD_NOP    = 0;
  localparam int CMD_WR_RHO = 1;
  localparam int CMD_WR_SIG = 2;
  localparam int CMD_START  = 3;
  localparam int CMD_ABORT  = 4;

  localparam logic [2:0] TAG_RHO = 3'd0;
  localparam logic [2:0] TAG_A   = 3'd1;
  localparam logic [2:0] TAG_SIG = 3'd2;
  localparam logic [2:0] TAG_S   = 3'd3;
  localparam logic [2:0] TAG_E   = 3'd4;

  // i/j/N counters are 3 bits wide, so k can never exceed 7
  localparam int K_MAX_LIMIT = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RHO,
    S_AMAT,
    S_SIGMA,
    S_SVEC,
    S_EVEC,
    S_DONE
  } state_t;

endpackage

// File: rtl/keygen_seed_rf.sv
// Seed storage: rho (sel=0) and sigma (sel=1), N_WORDS words each.
// One synchronous write port, one combinational read port.
module keygen_seed_rf #(
  parameter int BW_DATA = 32,
  parameter int N_WORDS = 8,
  parameter int IW      = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               we,
  input  logic               wsel,
  input  logic [IW-1:0]      widx,
  input  logic [BW_DATA-1:0] wdata,
  input  logic               rsel,
  input  logic [IW-1:0]      ridx,
  output logic [BW_DATA-1:0] rdata
);

  logic [1:0][N_WORDS-1:0][BW_DATA-1:0] mem;

  always_ff @(posedge i_clk) begin
    if (i_rst)   mem <= '0;
    else if (we) mem[wsel][widx] <= wdata;
  end

  assign rdata = mem[rsel][ridx];

endmodule

// File: rtl/keygen_sched.sv
// Kyber keygen descriptor scheduler: streams rho words, A-matrix XOF jobs,
// sigma words and s/e PRF jobs over a registered valid/ready interface.
import kyber_pkg::*;

module keygen_sched #(
  parameter int BW_DATA   = 32,
  parameter int BW_ADDR   = 4,
  parameter int BW_CTRL   = 4,
  parameter int K_MAX     = 4,
  parameter int SEED_BITS = 256
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BW_CTRL-1:0] i_ctrl,
  input  logic [BW_ADDR-1:0] i_addr,
  input  logic [BW_DATA-1:0] i_data,
  input  logic               i_ready,
  output logic [BW_DATA-1:0] o_data,
  output logic [2:0]         o_tag,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam int N_WORDS = SEED_BITS / BW_DATA;
  localparam int IW      = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IW-1:0]    W_LAST   = IW'(N_WORDS - 1);
  localparam logic [BW_ADDR:0] ADDR_LIM = (BW_ADDR + 1)'(N_WORDS);
  localparam logic [2:0]       K_MAX3   = 3'(K_MAX);

  if (K_MAX > K_MAX_LIMIT || K_MAX < 2) begin : g_bad_kmax
    $error("keygen_sched: K_MAX must be in 2..7");
  end
  if (SEED_BITS % BW_DATA != 0 || BW_DATA < 16) begin : g_bad_bw
    $error("keygen_sched: BW_DATA must divide SEED_BITS and be >= 16");
  end

  state_t            state, nxt_state;
  logic [IW-1:0]     w_idx, nxt_w;
  logic [2:0]        i_idx, j_idx, n_idx, nxt_i, nxt_j, nxt_n;
  logic [2:0]        k_reg, k_m1, k_in;
  logic              is_wr, is_start, is_abort, addr_ok, k_ok, advance;
  logic              rf_we, rf_rsel, err_set, err_clr, k_ld;
  logic [BW_DATA-1:0] rf_rdata, beat_data;
  logic [2:0]        beat_tag;

  assign is_wr    = (i_ctrl == BW_CTRL'(CMD_WR_RHO)) || (i_ctrl == BW_CTRL'(CMD_WR_SIG));
  assign is_start = (i_ctrl == BW_CTRL'(CMD_START));
  assign is_abort = (i_ctrl == BW_CTRL'(CMD_ABORT));
  assign addr_ok  = {1'b0, i_addr} < ADDR_LIM;
  assign k_in     = i_data[2:0];
  assign k_ok     = (k_in >= 3'd2) && (k_in <= K_MAX3);
  assign k_m1     = k_reg - 3'd1;
  assign advance  = o_valid && i_ready;

  assign o_valid  = (state != S_IDLE) && (state != S_DONE);
  assign o_busy   = (state != S_IDLE);
  assign o_done   = (state == S_DONE);

  keygen_seed_rf #(.BW_DATA(BW_DATA), .N_WORDS(N_WORDS), .IW(IW)) u_seed_rf (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .we    (rf_we),
    .wsel  (i_ctrl == BW_CTRL'(CMD_WR_SIG)),
    .widx  (i_addr[IW-1:0]),
    .wdata (i_data),
    .rsel  (rf_rsel),
    .ridx  (nxt_w),
    .rdata (rf_rdata)
  );

  // Command decode and beat sequencing; ABORT outranks every other command.
  always_comb begin
    nxt_state = state;
    nxt_w     = w_idx;
    nxt_i     = i_idx;
    nxt_j     = j_idx;
    nxt_n     = n_idx;
    rf_we     = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    k_ld      = 1'b0;
    if (state == S_IDLE) begin
      if (is_wr) begin
        if (addr_ok) rf_we = 1'b1;
        else         err_set = 1'b1;
      end else if (is_start) begin
        if (k_ok) begin
          nxt_state = S_RHO;
          nxt_w     = '0;
          err_clr   = 1'b1;
          k_ld      = 1'b1;
        end else begin
          err_set = 1'b1;
        end
      end
    end else if (is_abort) begin
      nxt_state = S_IDLE;
    end else begin
      err_set = is_wr || is_start;
      if (state == S_DONE) begin
        nxt_state = S_IDLE;
      end else if (advance) begin
        case (state)
          S_RHO:
            if (w_idx == W_LAST) begin
              nxt_state = S_AMAT;
              nxt_i     = '0;
              nxt_j     = '0;
            end else nxt_w = w_idx + 1'b1;
          S_AMAT:
            if (j_idx == k_m1) begin
              nxt_j = '0;
              if (i_idx == k_m1) begin
                nxt_state = S_SIGMA;
                nxt_w     = '0;
              end else nxt_i = i_idx + 3'd1;
            end else nxt_j = j_idx + 3'd1;
          S_SIGMA:
            if (w_idx == W_LAST) begin
              nxt_state = S_SVEC;
              nxt_n     = '0;
            end else nxt_w = w_idx + 1'b1;
          S_SVEC:
            if (n_idx == k_m1) begin
              nxt_state = S_EVEC;
              nxt_n     = '0;
            end else nxt_n = n_idx + 3'd1;
          S_EVEC:
            if (n_idx == k_m1) nxt_state = S_DONE;
            else               nxt_n = n_idx + 3'd1;
          default: ;
        endcase
      end
    end
  end

  // Content of the beat that will be on the bus after this edge; it equals the
  // current beat while stalled, which keeps o_data/o_tag stable.
  assign rf_rsel = (nxt_state == S_SIGMA);

  always_comb begin
    beat_data = '0;
    beat_tag  = TAG_RHO;
    case (nxt_state)
      S_RHO:   begin beat_data = rf_rdata; beat_tag = TAG_RHO; end
      S_AMAT:  begin beat_data[15:0] = {5'b0, nxt_i, 5'b0, nxt_j}; beat_tag = TAG_A; end
      S_SIGMA: begin beat_data = rf_rdata; beat_tag = TAG_SIG; end
      S_SVEC:  begin beat_data[7:0] = {5'b0, nxt_n}; beat_tag = TAG_S; end
      S_EVEC:  begin beat_data[7:0] = {5'b0, nxt_n} + {5'b0, k_reg}; beat_tag = TAG_E; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      w_idx  <= '0;
      i_idx  <= '0;
      j_idx  <= '0;
      n_idx  <= '0;
      k_reg  <= '0;
      o_err  <= 1'b0;
      o_data <= '0;
      o_tag  <= '0;
    end else begin
      state  <= nxt_state;
      w_idx  <= nxt_w;
      i_idx  <= nxt_i;
      j_idx  <= nxt_j;
      n_idx  <= nxt_n;
      if (k_ld) k_reg <= k_in;
      if (err_clr)      o_err <= 1'b0;
      else if (err_set) o_err <= 1'b1;
      o_data <= beat_data;
      o_tag  <= beat_tag;
    end
  end

endmodule

// File: tb/tb_keygen_sched.sv
// Directed bench for keygen_sched: seed load, full streams for k=2/3/4,
// stalls, illegal commands, abort, busy-time commands and mid-stream reset.
module tb_keygen_sched;

  localparam int NW = 8;
  localparam logic [3:0] C_NOP = 4'd0, C_WR_RHO = 4'd1, C_WR_SIG = 4'd2;
  localparam logic [3:0] C_START = 4'd3, C_ABORT = 4'd4;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ready;
  logic [3:0]  i_ctrl, i_addr;
  logic [31:0] i_data, o_data;
  logic [2:0]  o_tag;
  logic        o_valid, o_busy, o_done, o_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] rho_m [NW];
  logic [31:0] sig_m [NW];

  always #5 i_clk = ~i_clk;

  keygen_sched dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_ctrl  (i_ctrl),
    .i_addr  (i_addr),
    .i_data  (i_data),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_tag   (o_tag),
    .o_valid (o_valid),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_err   (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge i_clk);
  endtask

  task automatic cmd(input logic [3:0] c, input logic [3:0] a, input logic [31:0] d);
    i_ctrl = c; i_addr = a; i_data = d;
    step;
    i_ctrl = C_NOP; i_addr = '0; i_data = '0;
  endtask

  // Expected beat b of a k-rank sequence
  task automatic exp_beat(input int k, input int b, output logic [31:0] d, output logic [2:0] t);
    int a;
    if (b < NW) begin
      d = rho_m[b]; t = 3'd0;
    end else if (b < NW + k*k) begin
      a = b - NW;
      d = 32'((a / k) * 256 + (a % k)); t = 3'd1;
    end else if (b < 2*NW + k*k) begin
      d = sig_m[b - NW - k*k]; t = 3'd2;
    end else if (b < 2*NW + k*k + k) begin
      d = 32'(b - 2*NW - k*k); t = 3'd3;
    end else begin
      d = 32'(b - 2*NW - k*k); t = 3'd4;
    end
  endtask

  // START k, then drain the stream; optional ABORT after abort_at beats,
  // optional WR_RHO/START injected while busy.
  task automatic stream(input int k, input int rdy_pct, input int abort_at, input bit wr_mid);
    int nb, got, cyc, ph;
    logic [31:0] ed, pd;
    logic [2:0]  et, pt;
    bit stalled;
    nb = 2*NW + k*k + 2*k; got = 0; cyc = 0; ph = 0; stalled = 0; pd = '0; pt = '0;
    cmd(C_START, 4'd0, 32'(k));
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_err", 32'(o_err), 32'd0);
    while (got < nb && cyc < 1000) begin
      i_ready = ($urandom_range(0, 99) < rdy_pct);
      chk("valid", 32'(o_valid), 32'd1);
      if (stalled) begin
        chk("hold_data", o_data, pd);
        chk("hold_tag", 32'(o_tag), 32'(pt));
      end
      if (o_valid && i_ready) begin
        exp_beat(k, got, ed, et);
        chk($sformatf("data_k%0d_b%0d", k, got), o_data, ed);
        chk($sformatf("tag_k%0d_b%0d", k, got), 32'(o_tag), 32'(et));
        if (k == 4 && got == 23) chk("last_a", o_data, 32'h0000_0303);
        if (k == 4 && got == nb - 1) chk("last_e", o_data, 32'd7);
        got++;
        stalled = 0;
      end else begin
        stalled = 1; pd = o_data; pt = o_tag;
      end
      if (got == abort_at) i_ctrl = C_ABORT;
      if (wr_mid) begin
        if (ph == 0 && got >= 3) begin
          i_ctrl = C_WR_RHO; i_addr = 4'd7; i_data = 32'hDEAD_BEEF; ph = 1;
        end else if (ph == 1) begin
          i_ctrl = C_START; i_addr = '0; i_data = 32'd3; ph = 2;
        end else if (ph == 2) begin
          i_ctrl = C_NOP; i_data = '0; ph = 3;
        end
      end
      step;
      cyc++;
      if (i_ctrl == C_ABORT) begin
        i_ctrl = C_NOP;
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_err", 32'(o_err), 32'd0);
        step;
        chk("abort_done2", 32'(o_done), 32'd0);
        return;
      end
    end
    i_ctrl = C_NOP; i_data = '0;
    chk("beats", 32'(got), 32'(nb));
    chk("done_valid", 32'(o_valid), 32'd0);
    chk("done", 32'(o_done), 32'd1);
    chk("done_busy", 32'(o_busy), 32'd1);
    step;
    chk("done_clr", 32'(o_done), 32'd0);
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_valid", 32'(o_valid), 32'd0);
    if (wr_mid) chk("busy_err", 32'(o_err), 32'd1);
  endtask

  initial begin
    i_rst = 1'b1; i_ctrl = C_NOP; i_addr = '0; i_data = '0; i_ready = 1'b0;
    step; step;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_tag", 32'(o_tag), 32'd0);
    i_rst = 1'b0;

    // 1: seed load and k=2 at full rate
    for (int w = 0; w < NW; w++) begin
      rho_m[w] = 32'h1000_0000 + 32'(w);
      sig_m[w] = 32'h2000_0000 + 32'(w);
      cmd(C_WR_RHO, 4'(w), rho_m[w]);
      cmd(C_WR_SIG, 4'(w), sig_m[w]);
    end
    stream(2, 100, -1, 1'b0);

    // 2: k=4 with random stalls
    stream(4, 50, -1, 1'b0);

    // 3: illegal k and out-of-range seed address
    cmd(C_START, 4'd0, 32'd1);
    chk("k1_valid", 32'(o_valid), 32'd0);
    chk("k1_busy", 32'(o_busy), 32'd0);
    chk("k1_err", 32'(o_err), 32'd1);
    cmd(C_START, 4'd0, 32'd5);
    chk("k5_valid", 32'(o_valid), 32'd0);
    chk("k5_busy", 32'(o_busy), 32'd0);
    cmd(C_WR_RHO, 4'd8, 32'hBAD0_0000);
    chk("wr8_valid", 32'(o_valid), 32'd0);
    chk("wr8_err", 32'(o_err), 32'd1);
    stream(3, 100, -1, 1'b0);

    // 4: abort after 10 beats, then replay
    stream(3, 100, 10, 1'b0);
    stream(3, 100, -1, 1'b0);

    // 5: commands while busy are ignored
    stream(2, 100, -1, 1'b1);

    // 6: reset while stalled in A-matrix phase
    cmd(C_START, 4'd0, 32'd2);
    i_ready = 1'b1;
    repeat (9) step;
    i_ready = 1'b0;
    step;
    chk("stall_valid", 32'(o_valid), 32'd1);
    chk("stall_data", o_data, 32'h0000_0001);
    chk("stall_tag", 32'(o_tag), 32'd1);
    i_rst = 1'b1;
    step;
    i_rst = 1'b0;
    chk("mrst_valid", 32'(o_valid), 32'd0);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    chk("mrst_done", 32'(o_done), 32'd0);
    chk("mrst_data", o_data, 32'd0);
    chk("mrst_tag", 32'(o_tag), 32'd0);
    for (int w = 0; w < NW; w++) begin
      rho_m[w] = '0;
      sig_m[w] = '0;
    end
    stream(2, 100, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
